accum_bank: RTL
===============

ACCUM_BANK -- requirements
Module: accum_bank

Interface
REQ-001 Parameter ARR_SIZE, default 4: number of systolic-array columns (partial sums per beat), >= 2.
REQ-002 Parameter VERTICAL_BW, default 32: width of one column partial sum, signed two's complement.
REQ-003 Parameter DEPTH, default 16: number of accumulation entries; ADDR_W = clog2(DEPTH); COL_W = clog2(ARR_SIZE).
REQ-004 Parameter SATURATE, default 1: 1 = clamp on overflow, 0 = wrap.
REQ-005 Parameter CLEAR_ON_DRAIN, default 1: 1 = entry zeroed after full drain.
REQ-006 clk  in  1  single clock; all state on rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-high.
REQ-008 in_valid  in  1  partial-sum beat present.
REQ-009 in_first  in  1  beat overwrites entry instead of adding.
REQ-010 in_addr  in  ADDR_W  target entry.
REQ-011 in_data  in  ARR_SIZE*VERTICAL_BW  column k at bits [(k+1)*VERTICAL_BW-1 : k*VERTICAL_BW].
REQ-012 in_ready  out  1  beat accepted when in_valid & in_ready.
REQ-013 drain_req  in  1  one-cycle request to stream one entry out.
REQ-014 drain_addr  in  ADDR_W  entry to drain, sampled with drain_req.
REQ-015 drain_busy  out  1  drain in progress.
REQ-016 out_valid  out  1  output beat present.
REQ-017 out_ready  in  1  downstream (output buffer) accepts beat.
REQ-018 out_data  out  VERTICAL_BW  column value.
REQ-019 out_addr  out  ADDR_W  entry being drained; out_col  out  COL_W  column index.
REQ-020 out_last  out  1  high on column ARR_SIZE-1 beat.
REQ-021 ovf_flag  out  1  sticky overflow; ovf_clr  in  1  synchronous clear.

Function
REQ-022 Storage: DEPTH x ARR_SIZE registers of VERTICAL_BW bits.
REQ-023 Accept (in_valid & in_ready): per column k, entry[in_addr][k] <= in_first ? in_data_k : entry[in_addr][k] + in_data_k; written at that clock edge, visible to next beat (back-to-back same address accumulates correctly, no stall).
REQ-024 Addition signed, VERTICAL_BW+1 internal; overflow when result outside signed range.
REQ-025 Overflow, SATURATE=1: store 2^(VERTICAL_BW-1)-1 (positive) or -2^(VERTICAL_BW-1) (negative); SATURATE=0: store low VERTICAL_BW bits; either mode sets ovf_flag next cycle.
REQ-026 ovf_flag cleared by ovf_clr; same-cycle overflow and ovf_clr: flag remains set.
REQ-027 FSM states IDLE, DRAIN. IDLE: in_ready=1, out_valid=0, drain_busy=0.
REQ-028 IDLE & drain_req: latch drain_addr, col=0, go DRAIN next cycle.
REQ-029 IDLE, in_valid and drain_req same cycle: beat accepted first; drain observes updated entry.
REQ-030 DRAIN: in_ready=0, drain_busy=1, out_valid=1, out_data=entry[latched][col], out_addr=latched, out_col=col.
REQ-031 out_data/out_col stable while out_valid & !out_ready; col advances only on handshake.
REQ-032 Handshake at col=ARR_SIZE-1 (out_last=1): return IDLE; CLEAR_ON_DRAIN=1 zeroes all columns of that entry on that edge.
REQ-033 drain_req in DRAIN ignored; in_valid in DRAIN not accepted (held by source).
REQ-034 Out-of-range address (>= DEPTH when DEPTH not power of 2): beat/drain request dropped, no state change.

Reset
REQ-035 rst high: all entries 0, FSM IDLE, col 0, ovf_flag 0, out_valid 0, out_data 0, out_addr 0, out_col 0, out_last 0, drain_busy 0, in_ready 1; asynchronous, effective without clock.
REQ-036 rst mid-drain aborts drain; no further out_valid until new drain_req after release.

Verification
REQ-037 Beats {1,2,3,4} in_first=1 then {10,20,30,40} to addr 3, drain 3, out_ready=1 -> 4 beats 11,22,33,44, out_col 0..3, out_last on 4th, entry 3 reads 0 afterward.
REQ-038 Drain with out_ready toggling 1,0,0,1... -> each value held stable until accepted, exactly ARR_SIZE handshakes, drain_busy low cycle after last.
REQ-039 SATURATE=1: entry 0x7FFFFFF0 + 0x20 -> 0x7FFFFFFF, ovf_flag=1; SATURATE=0 -> 0x80000010, ovf_flag=1; ovf_clr -> 0.
REQ-040 in_valid and drain_req same cycle, addr 5, entry 7, beat 1 -> drained column value 8; in_ready=0 throughout drain.
REQ-041 Assert rst during column 2 of drain -> out_valid 0 immediately, all entries 0, in_ready 1 after release.

Source files
------------

// File: rtl/accum_bank.sv
// Accumulation bank: DEPTH entries of ARR_SIZE signed column partial sums,
// accumulated per beat and streamed out one column per handshake.
module accum_bank #(
  parameter int ARR_SIZE       = 4,
  parameter int VERTICAL_BW    = 32,
  parameter int DEPTH          = 16,
  parameter int SATURATE       = 1,
  parameter int CLEAR_ON_DRAIN = 1,
  localparam int ADDR_W        = $clog2(DEPTH),
  localparam int COL_W         = $clog2(ARR_SIZE)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  input  logic                            in_first,
  input  logic [ADDR_W-1:0]               in_addr,
  input  logic [ARR_SIZE*VERTICAL_BW-1:0] in_data,
  output logic                            in_ready,
  input  logic                            drain_req,
  input  logic [ADDR_W-1:0]               drain_addr,
  output logic                            drain_busy,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [VERTICAL_BW-1:0]          out_data,
  output logic [ADDR_W-1:0]               out_addr,
  output logic [COL_W-1:0]                out_col,
  output logic                            out_last,
  output logic                            ovf_flag,
  input  logic                            ovf_clr
);

  typedef enum logic [0:0] {IDLE = 1'b0, DRAIN = 1'b1} state_t;

  state_t                   state_r;
  state_t                   state_nxt_s;
  logic [VERTICAL_BW-1:0]   entry_r [DEPTH][ARR_SIZE];
  logic [ADDR_W-1:0]        drain_addr_r;
  logic [COL_W-1:0]         col_r;
  logic [COL_W-1:0]         col_nxt_s;
  logic [VERTICAL_BW-1:0]   out_data_r;
  logic [VERTICAL_BW-1:0]   first_col_s;
  logic                     ovf_flag_r;
  logic                     in_addr_ok_s;
  logic                     drain_addr_ok_s;
  logic                     accept_s;
  logic                     drain_start_s;
  logic                     out_hs_s;
  logic                     last_col_s;
  logic                     ovf_any_s;
  logic                     in_ready_s;
  logic                     drain_busy_s;
  logic                     out_valid_s;
  logic [VERTICAL_BW-1:0]   wr_val_s [ARR_SIZE];
  logic [ARR_SIZE-1:0]      col_ovf_s;

  // Signed add with one guard bit; returns {overflow, stored value}.
  function automatic logic [VERTICAL_BW:0] add_clamp(input logic [VERTICAL_BW-1:0] a,
                                                     input logic [VERTICAL_BW-1:0] b);
    logic [VERTICAL_BW:0]   sum;
    logic                   ovf;
    logic [VERTICAL_BW-1:0] res;
    sum = {a[VERTICAL_BW-1], a} + {b[VERTICAL_BW-1], b};
    ovf = sum[VERTICAL_BW] ^ sum[VERTICAL_BW-1];
    if (ovf && (SATURATE != 0)) begin
      res = sum[VERTICAL_BW] ? {1'b1, {(VERTICAL_BW-1){1'b0}}}
                             : {1'b0, {(VERTICAL_BW-1){1'b1}}};
    end else begin
      res = sum[VERTICAL_BW-1:0];
    end
    return {ovf, res};
  endfunction

  // Non-power-of-two depths need a range check; otherwise every address is valid.
  generate
    if (DEPTH == (2 ** ADDR_W)) begin : g_full_range
      assign in_addr_ok_s    = 1'b1;
      assign drain_addr_ok_s = 1'b1;
    end else begin : g_range_check
      assign in_addr_ok_s    = ({1'b0, in_addr}    < (ADDR_W+1)'(DEPTH));
      assign drain_addr_ok_s = ({1'b0, drain_addr} < (ADDR_W+1)'(DEPTH));
    end
  endgenerate

  assign accept_s      = in_valid & in_ready_s & in_addr_ok_s;
  assign drain_start_s = (state_r == IDLE) & drain_req & drain_addr_ok_s;
  assign out_hs_s      = (state_r == DRAIN) & out_ready;
  assign last_col_s    = (col_r == COL_W'(ARR_SIZE-1));
  assign col_nxt_s     = col_r + COL_W'(1);
  assign ovf_any_s     = accept_s & (|col_ovf_s);
  // A same-cycle beat to the drained entry must be visible in the first column out.
  assign first_col_s   = (accept_s && (in_addr == drain_addr)) ? wr_val_s[0]
                                                               : entry_r[drain_addr][0];

  // Per-column write value for an accepted beat.
  always_comb begin
    for (int k = 0; k < ARR_SIZE; k++) begin
      wr_val_s[k]  = '0;
      col_ovf_s[k] = 1'b0;
      if (in_first) begin
        wr_val_s[k] = in_data[k*VERTICAL_BW +: VERTICAL_BW];
      end else begin
        {col_ovf_s[k], wr_val_s[k]} = add_clamp(entry_r[in_addr][k],
                                                in_data[k*VERTICAL_BW +: VERTICAL_BW]);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    state_nxt_s = drain_start_s ? DRAIN : IDLE;
      DRAIN:   state_nxt_s = (out_hs_s && last_col_s) ? IDLE : DRAIN;
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM output decode.
  always_comb begin
    in_ready_s   = 1'b1;
    drain_busy_s = 1'b0;
    out_valid_s  = 1'b0;
    case (state_r)
      IDLE: begin
        in_ready_s   = 1'b1;
        drain_busy_s = 1'b0;
        out_valid_s  = 1'b0;
      end
      DRAIN: begin
        in_ready_s   = 1'b0;
        drain_busy_s = 1'b1;
        out_valid_s  = 1'b1;
      end
      default: begin
        in_ready_s   = 1'b1;
        drain_busy_s = 1'b0;
        out_valid_s  = 1'b0;
      end
    endcase
  end

  // Entry storage, drain pointer, output data register and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int e = 0; e < DEPTH; e++) begin
        for (int k = 0; k < ARR_SIZE; k++) begin
          entry_r[e][k] <= '0;
        end
      end
      drain_addr_r <= '0;
      col_r        <= '0;
      out_data_r   <= '0;
      ovf_flag_r   <= 1'b0;
    end else begin
      ovf_flag_r <= (ovf_flag_r & ~ovf_clr) | ovf_any_s;
      if (accept_s) begin
        for (int k = 0; k < ARR_SIZE; k++) begin
          entry_r[in_addr][k] <= wr_val_s[k];
        end
      end
      if (drain_start_s) begin
        drain_addr_r <= drain_addr;
        col_r        <= '0;
        out_data_r   <= first_col_s;
      end else if (out_hs_s) begin
        if (last_col_s) begin
          col_r      <= '0;
          out_data_r <= '0;
          if (CLEAR_ON_DRAIN != 0) begin
            for (int k = 0; k < ARR_SIZE; k++) begin
              entry_r[drain_addr_r][k] <= '0;
            end
          end
        end else begin
          col_r      <= col_nxt_s;
          out_data_r <= entry_r[drain_addr_r][col_nxt_s];
        end
      end else begin
        col_r      <= col_r;
        out_data_r <= out_data_r;
      end
    end
  end

  assign in_ready   = in_ready_s;
  assign drain_busy = drain_busy_s;
  assign out_valid  = out_valid_s;
  assign out_data   = out_data_r;
  assign out_addr   = drain_addr_r;
  assign out_col    = col_r;
  assign out_last   = out_valid_s & last_col_s;
  assign ovf_flag   = ovf_flag_r;

endmodule
